if_id_queue: RTL and testbench
==============================

# if_id_queue

Pipeline buffer between `instruction_fetch` and the decode stage. It captures each fetched instruction together with its PC and PC+1 value in a small FIFO, and presents them to decode through a valid/ready handshake. It back-pressures fetch through `o_stall` when full and discards all in-flight entries on a branch/jump flush. When empty it outputs a NOP bubble.

## Interface
Parameters:
- `SIZE`, 32, data width of instruction, PC and PC+1 fields
- `DEPTH`, 2, number of entries; legal range 2..16, need not be a power of two

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset)
- `i_instruction`  in  SIZE  instruction from fetch
- `i_pc`  in  SIZE  PC of that instruction
- `i_adder`  in  SIZE  PC+1 from fetch adder
- `i_valid`  in  1  fetch presents a valid instruction this cycle
- `o_stall`  out  1  queue full; drives fetch `i_stall`
- `i_flush`  in  1  branch/jump taken; discard all entries
- `i_ready`  in  1  decode accepts head entry this cycle
- `o_valid`  out  1  head entry valid
- `o_instruction`  out  SIZE  head instruction, or NOP (0) when empty
- `o_pc`  out  SIZE  head PC, or 0 when empty
- `o_adder`  out  SIZE  head PC+1, or 0 when empty

## Operation
- Storage: DEPTH entries of {instruction, pc, adder}; write pointer, read pointer, and a count of 0..DEPTH.
- Push: `i_valid && !full && !i_flush` writes the entry at the write pointer and advances that pointer.
- Pop: `o_valid && i_ready && !i_flush` advances the read pointer.
- Push and pop in the same cycle: count unchanged. When full, push is refused even if pop occurs; `o_stall` depends only on count.
- Pointers wrap from DEPTH-1 to 0 explicitly; there is no modulo by power of two.
- `o_stall = (count == DEPTH)`. `o_valid = (count != 0)`.
- When `o_valid` is 0, `o_instruction`, `o_pc` and `o_adder` are 0 (NOP bubble). This is required regardless of stale storage contents.
- Flush has the highest priority below reset. In the cycle `i_flush` is 1, count and both pointers go to 0, and any push or pop that cycle is discarded. The queue accepts pushes again on the next cycle.
- Arithmetic: count width is $clog2(DEPTH+1). Pointer width is $clog2(DEPTH). The data fields are stored verbatim, with no width conversion.

## Timing
- Reset (`rst`=0): count, pointers, `o_valid`, `o_stall` and all data outputs are 0 immediately, without waiting for a clock edge. Storage contents need not be cleared.
- Reset mid-operation: all entries are lost. The first push after `rst` rises is visible one cycle later.
- Latency: an entry pushed at edge N appears on the outputs after edge N, provided the queue was empty. Otherwise it appears behind older entries in FIFO order.
- Outputs are combinational from registered state only; there is no combinational path from `i_*` to `o_*`.
- `o_stall` rises after the edge that fills the queue. It falls after the first edge that pops or flushes.

## Configuration
- `IF_ID_QUEUE_STATS_EN` defined: adds output ports `o_stall_cycles` [31:0], which counts cycles with `o_stall`=1, and `o_flush_count` [31:0], which counts cycles with `i_flush`=1. Both saturate at all-ones and are cleared by `rst`.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR` constant (32'h0)
  - `if_id_entry_t` struct {instruction, pc, adder}
  - default `SIZE`
- Sub-module `if_id_fifo_mem`: DEPTH-entry register array with write enable/address and an asynchronous read port. The pointer, count and flush control stay in `if_id_queue`.

## Test plan
- Reset then idle:
  - hold `rst`=0 for 3 cycles, then release with `i_valid`=0 → `o_valid`=0, `o_instruction`=0, `o_stall`=0 throughout.
- Single pass-through:
  - push {32'h3C010003, pc 0, adder 1} with `i_ready`=1 → outputs show it for exactly one cycle, then return to NOP.
- Fill and back-pressure:
  - with DEPTH=2 and `i_ready`=0, push pc 0,1,2 → `o_stall`=1 after the second push and pc 2 is not stored.
  - then assert `i_ready` for 2 cycles → heads pc 0 then pc 1 appear, and `o_stall` falls.
- Flush priority:
  - fill with pc 3,4; assert `i_flush` together with `i_valid` (pc 5) and `i_ready` → next cycle `o_valid`=0 and count is 0.
  - a subsequent push of pc 5 appears alone.
- Wrap-around:
  - with DEPTH=3, stream 10 instructions with alternating `i_ready` → outputs emerge in order pc 0..9, with no loss or duplication.
- Async reset mid-stream:
  - drop `rst` between edges while count is 2 → `o_valid` goes to 0 before the next edge.
  - with `IF_ID_QUEUE_STATS_EN`, the counters also read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default datapath width, NOP encoding and the IF/ID entry.
package mips_pkg;

  localparam int unsigned SIZE_DEFAULT = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [SIZE_DEFAULT-1:0] instruction;
    logic [SIZE_DEFAULT-1:0] pc;
    logic [SIZE_DEFAULT-1:0] adder;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Register array for the IF/ID queue: one synchronous write port, one asynchronous read port.
module if_id_fifo_mem #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the queue masks stale entries via its count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID pipeline buffer: small FIFO with valid/ready to decode, stall to fetch, flush and NOP bubble.
// Optional IF_ID_QUEUE_STATS_EN adds saturating stall-cycle and flush counters.
module if_id_queue
  import mips_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] i_instruction,
  input  logic [SIZE-1:0] i_pc,
  input  logic [SIZE-1:0] i_adder,
  input  logic            i_valid,
  output logic            o_stall,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [SIZE-1:0] o_instruction,
  output logic [SIZE-1:0] o_pc,
`ifdef IF_ID_QUEUE_STATS_EN
  output logic [31:0]     o_stall_cycles,
  output logic [31:0]     o_flush_count,
`endif
  output logic [SIZE-1:0] o_adder
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [SIZE-1:0] instruction;
    logic [SIZE-1:0] pc;
    logic [SIZE-1:0] adder;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, push, pop;
  entry_t           wr_entry, rd_entry;

  assign full    = (count_q == FULL_CNT);
  assign o_stall = full;
  assign o_valid = (count_q != '0);
  assign push    = i_valid && !full && !i_flush;
  assign pop     = o_valid && i_ready && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{instruction: i_instruction, pc: i_pc, adder: i_adder};

  if_id_fifo_mem #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Empty queue presents a NOP bubble whatever stale data sits in storage.
  assign o_instruction = o_valid ? rd_entry.instruction : SIZE'(NOP_INSTR);
  assign o_pc          = o_valid ? rd_entry.pc          : '0;
  assign o_adder       = o_valid ? rd_entry.adder       : '0;

`ifdef IF_ID_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (o_stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (i_flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: DEPTH=2 and DEPTH=3 instances driven in lockstep,
// each tracked by a queue scoreboard. Covers IF_ID_QUEUE_STATS_EN when defined.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ins = '0, pc = '0, add = '0;
  logic        vld = 1'b0, flush = 1'b0, rdy = 1'b0;

  logic        stall2, valid2, stall3, valid3;
  logic [31:0] ins2, pc2, add2, ins3, pc3, add3;
`ifdef IF_ID_QUEUE_STATS_EN
  logic [31:0] sc2, fc2, sc3, fc3;
  int unsigned m_sc2 = 0, m_sc3 = 0, m_fc = 0;
`endif

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] add;
  } ent_t;

  ent_t        q2[$];
  ent_t        q3[$];
  logic [31:0] got_pcs[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  if_id_queue #(.SIZE(32), .DEPTH(2)) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .i_instruction (ins),
    .i_pc          (pc),
    .i_adder       (add),
    .i_valid       (vld),
    .o_stall       (stall2),
    .i_flush       (flush),
    .i_ready       (rdy),
    .o_valid       (valid2),
    .o_instruction (ins2),
    .o_pc          (pc2),
`ifdef IF_ID_QUEUE_STATS_EN
    .o_stall_cycles(sc2),
    .o_flush_count (fc2),
`endif
    .o_adder       (add2)
  );

  if_id_queue #(.SIZE(32), .DEPTH(3)) u_dut3 (
    .clk           (clk),
    .rst           (rst),
    .i_instruction (ins),
    .i_pc          (pc),
    .i_adder       (add),
    .i_valid       (vld),
    .o_stall       (stall3),
    .i_flush       (flush),
    .i_ready       (rdy),
    .o_valid       (valid3),
    .o_instruction (ins3),
    .o_pc          (pc3),
`ifdef IF_ID_QUEUE_STATS_EN
    .o_stall_cycles(sc3),
    .o_flush_count (fc3),
`endif
    .o_adder       (add3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [31:0] p);
    return (p * 32'h0101_0101) ^ 32'hDEAD_0000;
  endfunction

  task automatic drive(input bit v, input logic [31:0] p, input bit r, input bit f);
    vld   = v;
    pc    = p;
    add   = p + 32'd1;
    ins   = mk_ins(p);
    rdy   = r;
    flush = f;
  endtask

  task automatic check_all();
    ent_t e2, e3;
    e2 = '{ins: '0, pc: '0, add: '0};
    e3 = '{ins: '0, pc: '0, add: '0};
    if (q2.size() != 0) e2 = q2[0];
    if (q3.size() != 0) e3 = q3[0];
    check("d2_valid", {31'd0, valid2}, {31'd0, q2.size() != 0});
    check("d2_stall", {31'd0, stall2}, {31'd0, q2.size() == 2});
    check("d2_instr", ins2, e2.ins);
    check("d2_pc",    pc2,  e2.pc);
    check("d2_adder", add2, e2.add);
    check("d3_valid", {31'd0, valid3}, {31'd0, q3.size() != 0});
    check("d3_stall", {31'd0, stall3}, {31'd0, q3.size() == 3});
    check("d3_instr", ins3, e3.ins);
    check("d3_pc",    pc3,  e3.pc);
    check("d3_adder", add3, e3.add);
`ifdef IF_ID_QUEUE_STATS_EN
    check("d2_stall_cycles", sc2, m_sc2);
    check("d3_stall_cycles", sc3, m_sc3);
    check("d2_flush_count",  fc2, m_fc);
    check("d3_flush_count",  fc3, m_fc);
`endif
  endtask

  // One clock: predict handshakes from the scoreboard, step it at the edge, then compare.
  task automatic cycle();
    bit   push2, pop2, push3, pop3;
    ent_t e;
    e     = '{ins: ins, pc: pc, add: add};
    push2 = vld && (q2.size() < 2) && !flush;
    pop2  = (q2.size() != 0) && rdy && !flush;
    push3 = vld && (q3.size() < 3) && !flush;
    pop3  = (q3.size() != 0) && rdy && !flush;
    if (pop3 && rst) got_pcs.push_back(pc3);
`ifdef IF_ID_QUEUE_STATS_EN
    if (rst) begin
      if (q2.size() == 2) m_sc2++;
      if (q3.size() == 3) m_sc3++;
      if (flush) m_fc++;
    end
`endif
    @(posedge clk);
    if (!rst || flush) begin
      q2.delete();
      q3.delete();
    end else begin
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back(e);
      if (pop3) void'(q3.pop_front());
      if (push3) q3.push_back(e);
    end
    #1;
    check_all();
  endtask

  initial begin
    int next;
    // Reset held, then idle.
    drive(0, 0, 0, 0);
    #1;
    check_all();
    repeat (3) cycle();
    rst = 1'b1;
    repeat (2) cycle();

    // Single pass-through with a known MIPS word.
    vld = 1'b1; ins = 32'h3C01_0003; pc = 32'd0; add = 32'd1; rdy = 1'b1; flush = 1'b0;
    cycle();
    check("pass_instr", ins2, 32'h3C01_0003);
    drive(0, 0, 1, 0);
    cycle();
    cycle();

    // Fill and back-pressure: DEPTH=2 refuses pc 2, DEPTH=3 keeps it.
    for (int p = 0; p < 3; p++) begin
      drive(1, p, 0, 0);
      cycle();
    end
    check("fill_stall2", {31'd0, stall2}, 32'd1);
    drive(0, 0, 1, 0);
    cycle();
    check("drain_head_pc1", pc2, 32'd1);
    cycle();
    check("drain_empty2", {31'd0, valid2}, 32'd0);
    cycle();

    // Flush beats a simultaneous push and pop.
    drive(1, 3, 0, 0); cycle();
    drive(1, 4, 0, 0); cycle();
    drive(1, 5, 1, 1); cycle();
    check("flush_empty2", {31'd0, valid2}, 32'd0);
    drive(1, 5, 0, 0); cycle();
    check("after_flush_pc5", pc3, 32'd5);
    drive(0, 0, 1, 0); cycle(); cycle();

    // Wrap-around stream with alternating ready; order checked on the DEPTH=3 instance.
    got_pcs.delete();
    next = 0;
    for (int c = 0; c < 80 && (next < 10 || q3.size() != 0); c++) begin
      bit acc;
      drive(next < 10, next, c % 2 == 1, 0);
      acc = (next < 10) && (q3.size() < 3);
      cycle();
      if (acc) next++;
    end
    check("wrap_count", got_pcs.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap_order_%0d", i), (i < got_pcs.size()) ? got_pcs[i] : 32'hFFFF_FFFF, i);
    end

    // Asynchronous reset mid-stream, between edges.
    drive(1, 20, 0, 0); cycle();
    drive(1, 21, 0, 0); cycle();
    check("pre_reset_valid3", {31'd0, valid3}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    q2.delete();
    q3.delete();
`ifdef IF_ID_QUEUE_STATS_EN
    m_sc2 = 0; m_sc3 = 0; m_fc = 0;
`endif
    check_all();
    drive(0, 0, 0, 0);
    #1;
    rst = 1'b1;
    drive(1, 30, 0, 0); cycle();
    check("post_reset_pc30", pc2, 32'd30);
    drive(0, 0, 1, 0); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
